// File: rtl/mem_bus_arbiter.sv
// mem_bus_arbiter
// Shares one memory bus port between the instruction-fetch bus and the data
// bus. One transaction is granted at a time with round-robin priority; the
// winning request is latched onto the m_* bus at grant and held there until
// the memory completes, then the completion is steered back to the owner.
//
// Ports
//   clk                 : only clock
//   reset               : asynchronous, active-low
//   i_valid/i_addr      : fetch request (held by requester until i_data_ok)
//   i_data_ok/i_data    : fetch completion pulse and 32-bit instruction word
//   d_valid/d_addr/d_size/d_strobe/d_wdata : data request (strobe 0 = read)
//   d_data_ok/d_data    : data completion pulse and load data
//   m_valid/m_addr/m_size/m_strobe/m_wdata : latched memory request
//   m_data_ok/m_data    : memory completion pulse and read data
//
// state  | meaning
// IDLE   | no transaction outstanding; arbitration happens here
// BUSY_I | fetch request owns the memory bus, waiting for m_data_ok
// BUSY_D | data request owns the memory bus, waiting for m_data_ok

module mem_bus_arbiter #(
  parameter int ADDR_W = 64,
  parameter int DATA_W = 64
) (
  input  logic                clk,
  input  logic                reset,

  input  logic                i_valid,
  input  logic [ADDR_W-1:0]   i_addr,
  output logic                i_data_ok,
  output logic [31:0]         i_data,

  input  logic                d_valid,
  input  logic [ADDR_W-1:0]   d_addr,
  input  logic [2:0]          d_size,
  input  logic [DATA_W/8-1:0] d_strobe,
  input  logic [DATA_W-1:0]   d_wdata,
  output logic                d_data_ok,
  output logic [DATA_W-1:0]   d_data,

  output logic                m_valid,
  output logic [ADDR_W-1:0]   m_addr,
  output logic [2:0]          m_size,
  output logic [DATA_W/8-1:0] m_strobe,
  output logic [DATA_W-1:0]   m_wdata,
  input  logic                m_data_ok,
  input  logic [DATA_W-1:0]   m_data
);

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    BUSY_I = 2'd1,
    BUSY_D = 2'd2
  } state_t;

  state_t              state_q;
  logic                last_d_q;   // 1 = last grant went to the data bus
  logic                m_valid_q;
  logic [ADDR_W-1:0]   m_addr_q;
  logic [2:0]          m_size_q;
  logic [DATA_W/8-1:0] m_strobe_q;
  logic [DATA_W-1:0]   m_wdata_q;

  // Data wins in IDLE when it is the only requester, or on a tie when the
  // previous grant was a fetch.
  logic grant_d;
  logic grant_i;
  assign grant_d = d_valid && (!i_valid || !last_d_q);
  assign grant_i = i_valid && !grant_d;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q    <= IDLE;
      last_d_q   <= 1'b0;
      m_valid_q  <= 1'b0;
      m_addr_q   <= '0;
      m_size_q   <= '0;
      m_strobe_q <= '0;
      m_wdata_q  <= '0;
    end else begin
      case (state_q)
        IDLE: begin
          if (grant_d) begin
            state_q    <= BUSY_D;
            last_d_q   <= 1'b1;
            m_valid_q  <= 1'b1;
            m_addr_q   <= d_addr;
            m_size_q   <= d_size;
            m_strobe_q <= d_strobe;
            m_wdata_q  <= d_wdata;
          end else if (grant_i) begin
            state_q    <= BUSY_I;
            last_d_q   <= 1'b0;
            m_valid_q  <= 1'b1;
            m_addr_q   <= i_addr;
            m_size_q   <= 3'b010;
            m_strobe_q <= '0;
            m_wdata_q  <= '0;
          end
        end
        BUSY_I, BUSY_D: begin
          // The transaction always runs to completion, even if the owner
          // drops its valid meanwhile.
          if (m_data_ok) begin
            state_q   <= IDLE;
            m_valid_q <= 1'b0;
          end
        end
        default: begin
          state_q   <= IDLE;
          m_valid_q <= 1'b0;
        end
      endcase
    end
  end

  assign m_valid  = m_valid_q;
  assign m_addr   = m_addr_q;
  assign m_size   = m_size_q;
  assign m_strobe = m_strobe_q;
  assign m_wdata  = m_wdata_q;

  // Completion is steered combinationally so the owner sees it with no
  // added latency; a stray m_data_ok in IDLE reaches nobody.
  assign i_data_ok = (state_q == BUSY_I) && m_data_ok;
  assign d_data_ok = (state_q == BUSY_D) && m_data_ok;

  assign d_data = m_data;

  generate
    if (DATA_W == 32) begin : g_fetch_32
      assign i_data = m_data;
    end else begin : g_fetch_wide
      // The word half is chosen by the latched address, not the live one.
      assign i_data = m_addr_q[2] ? m_data[63:32] : m_data[31:0];
    end
  endgenerate

endmodule

// File: tb/tb_mem_bus_arbiter.sv
module tb_mem_bus_arbiter;

  logic        clk;
  logic        reset;
  logic        i_valid;
  logic [63:0] i_addr;
  logic        i_data_ok;
  logic [31:0] i_data;
  logic        d_valid;
  logic [63:0] d_addr;
  logic [2:0]  d_size;
  logic [7:0]  d_strobe;
  logic [63:0] d_wdata;
  logic        d_data_ok;
  logic [63:0] d_data;
  logic        m_valid;
  logic [63:0] m_addr;
  logic [2:0]  m_size;
  logic [7:0]  m_strobe;
  logic [63:0] m_wdata;
  logic        m_data_ok;
  logic [63:0] m_data;

  int checks = 0;
  int fails  = 0;

  mem_bus_arbiter #(.ADDR_W(64), .DATA_W(64)) dut (
    .clk(clk), .reset(reset),
    .i_valid(i_valid), .i_addr(i_addr), .i_data_ok(i_data_ok), .i_data(i_data),
    .d_valid(d_valid), .d_addr(d_addr), .d_size(d_size), .d_strobe(d_strobe),
    .d_wdata(d_wdata), .d_data_ok(d_data_ok), .d_data(d_data),
    .m_valid(m_valid), .m_addr(m_addr), .m_size(m_size), .m_strobe(m_strobe),
    .m_wdata(m_wdata), .m_data_ok(m_data_ok), .m_data(m_data)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // Advance past the next rising edge; inputs are changed and outputs sampled
  // 1 time unit after the edge.
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    reset = 1'b0;
    step();
    step();
    reset = 1'b1;
  endtask

  initial begin
    logic [63:0] ia, da;
    logic        exp_d;

    reset = 1'b0;
    i_valid = 0; i_addr = '0;
    d_valid = 0; d_addr = '0; d_size = '0; d_strobe = '0; d_wdata = '0;
    m_data_ok = 0; m_data = '0;
    step();
    step();
    check("rst_m_valid",  m_valid,  0);
    check("rst_m_addr",   m_addr,   0);
    check("rst_m_size",   m_size,   0);
    check("rst_m_strobe", m_strobe, 0);
    check("rst_m_wdata",  m_wdata,  0);
    m_data_ok = 1; #1;
    check("rst_i_ok", i_data_ok, 0);
    check("rst_d_ok", d_data_ok, 0);
    m_data_ok = 0;
    reset = 1'b1;

    // Single fetch, upper word
    i_valid = 1; i_addr = 64'h8000_0004;
    #1 check("f_idle_m_valid", m_valid, 0);
    step();
    check("f_m_valid",  m_valid,  1);
    check("f_m_addr",   m_addr,   64'h8000_0004);
    check("f_m_size",   m_size,   3'd2);
    check("f_m_strobe", m_strobe, 0);
    check("f_m_wdata",  m_wdata,  0);
    step(); step();
    check("f_i_ok_wait", i_data_ok, 0);
    step();
    m_data_ok = 1; m_data = 64'h1111_2222_3333_4444; #1;
    check("f_i_ok",   i_data_ok, 1);
    check("f_i_data", i_data,    32'h1111_2222);
    check("f_d_ok",   d_data_ok, 0);
    step();
    m_data_ok = 0; i_valid = 0;
    check("f_done_m_valid", m_valid, 0);
    step();
    check("f_stay_idle", m_valid, 0);

    // Tie after reset: D, I, D, I
    do_reset();
    ia = 64'h8000_0000; da = 64'h9000_0040;
    i_valid = 1; i_addr = ia;
    d_valid = 1; d_addr = da; d_size = 3'd3; d_strobe = 8'h00; d_wdata = '0;
    exp_d = 1'b1;
    for (int n = 0; n < 4; n++) begin
      step();
      check($sformatf("tie%0d_m_valid", n), m_valid, 1);
      check($sformatf("tie%0d_m_addr", n), m_addr, exp_d ? da : ia);
      step();
      m_data_ok = 1; m_data = 64'hAAAA_BBBB_CCCC_DDDD; #1;
      check($sformatf("tie%0d_i_ok", n), i_data_ok, !exp_d);
      check($sformatf("tie%0d_d_ok", n), d_data_ok, exp_d);
      if (!exp_d) check($sformatf("tie%0d_i_data", n), i_data, 32'hCCCC_DDDD);
      else        check($sformatf("tie%0d_d_data", n), d_data, 64'hAAAA_BBBB_CCCC_DDDD);
      step();
      m_data_ok = 0;
      check($sformatf("tie%0d_idle", n), m_valid, 0);
      exp_d = !exp_d;
    end

    // Store with inputs changing while busy (last grant was I)
    i_valid = 0;
    d_valid = 1; d_addr = 64'h8000_1000; d_size = 3'd3;
    d_strobe = 8'hFF; d_wdata = 64'hDEAD_BEEF_0000_0001;
    step();
    d_addr = 64'h1234; d_size = 3'd0; d_strobe = 8'h01; d_wdata = 64'h5555;
    for (int n = 0; n < 2; n++) begin
      check("st_m_valid",  m_valid,  1);
      check("st_m_addr",   m_addr,   64'h8000_1000);
      check("st_m_size",   m_size,   3'd3);
      check("st_m_strobe", m_strobe, 8'hFF);
      check("st_m_wdata",  m_wdata,  64'hDEAD_BEEF_0000_0001);
      step();
    end
    m_data_ok = 1; m_data = 64'h0; #1;
    check("st_d_ok", d_data_ok, 1);
    check("st_i_ok", i_data_ok, 0);
    step();
    m_data_ok = 0; d_valid = 0;

    // Immediate completion; last grant was D so I wins the tie
    i_valid = 1; i_addr = 64'h8000_0100;
    d_valid = 1; d_addr = 64'h8000_2000; d_size = 3'd2; d_strobe = 8'h0F; d_wdata = 64'h77;
    step();
    check("imm_m_addr", m_addr, 64'h8000_0100);
    m_data_ok = 1; m_data = 64'h0000_0000_CAFE_F00D; #1;
    check("imm_i_ok",   i_data_ok, 1);
    check("imm_i_data", i_data,    32'hCAFE_F00D);
    step();
    m_data_ok = 0; i_valid = 0;
    check("imm_idle", m_valid, 0);
    step();
    check("imm_regrant",   m_valid, 1);
    check("imm_regrant_a", m_addr,  64'h8000_2000);
    m_data_ok = 1; #1;
    check("imm_d_ok", d_data_ok, 1);
    step();
    m_data_ok = 0; d_valid = 0;

    // Stray m_data_ok in IDLE
    m_data_ok = 1; #1;
    check("stray_i_ok", i_data_ok, 0);
    check("stray_d_ok", d_data_ok, 0);
    step();
    check("stray_m_valid", m_valid, 0);
    m_data_ok = 0;
    step();
    check("stray_still_idle", m_valid, 0);

    // Reset during BUSY_D (last grant D, so I would win a tie without reset)
    d_valid = 1; d_addr = 64'h8000_3000; d_size = 3'd3; d_strobe = 8'h00;
    step();
    check("rmid_busy", m_valid, 1);
    #2 reset = 1'b0;
    #1;
    check("rmid_m_valid_async", m_valid, 0);
    check("rmid_m_addr_async",  m_addr,  0);
    m_data_ok = 1; #1;
    check("rmid_d_ok", d_data_ok, 0);
    m_data_ok = 0;
    step();
    reset = 1'b1;
    i_valid = 1; i_addr = 64'h8000_0200;
    step();
    check("rmid_tie_d",  m_addr,  64'h8000_3000);
    check("rmid_valid",  m_valid, 1);
    step();
    m_data_ok = 1; #1;
    check("rmid_d_ok2", d_data_ok, 1);
    check("rmid_i_ok2", i_data_ok, 0);
    step();
    m_data_ok = 0; d_valid = 0;
    step();
    check("rmid_then_i", m_addr, 64'h8000_0200);
    i_valid = 0;

    $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL timeout observed=running expected=finished");
    $fatal(1, "timeout");
  end

endmodule
